uart_mem_loader: RTL and testbench

- UART-to-BRAM program loader on the I/O side of the memory port.
- Deserialises 8N1 bytes from the host serial line and pairs them into 16-bit words, high byte first.
- Writes each word to consecutive memory addresses through the I/O write port, before the processor and its cache are released.
- A terminator word ends the load and raises done.

---
 rtl/uart_mem_loader_if.sv | 12 +
 rtl/uart_mem_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_mem_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
// Memory I/O write port driven by the UART program loader.
// Registered address/data with a one-cycle write strobe; no backpressure from the memory side.
interface uart_mem_loader_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] addr_io;
    logic [15:0]       data_in_io;
    logic              we_io;

    modport master (output addr_io, data_in_io, we_io);
    modport slave  (input  addr_io, data_in_io, we_io);
endinterface

// File: rtl/uart_mem_loader.sv
// UART 8N1 receiver pairing bytes (high first) into 16-bit words written to consecutive addresses.
// we_io rises 2 cycles after the low byte's stop-bit sample; no backpressure, the memory port always accepts.
module uart_mem_loader #(
    parameter int                CLKS_PER_BIT = 868,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [15:0]       END_WORD     = 16'hFFFF
) (
    input  logic                      clk_100,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      rx,
    uart_mem_loader_if.master         mem,
    output logic                      led_rx,
    output logic                      done,
    output logic                      frame_err,
    output logic [15:0]               word_count
);
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_t;

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_armed;
    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_byte_vld;
    logic              r_led_rx;
    logic              r_frame_err;

    logic              r_phase_lo;
    logic [7:0]        r_hi;
    logic [15:0]       r_word;
    logic              r_word_vld;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic [15:0]       r_count;

    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // r_armed blocks a frame already in flight when enable rises; a high line must be seen first.
    always_ff @(posedge clk_100) begin
        if (rst || !enable) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            r_led_rx    <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_rx_sync)
                r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && !r_rx_sync) begin
                        r_state   <= ST_START;
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_led_rx  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_clk_cnt == CNT_HALF) begin
                        r_clk_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_led_rx <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_clk_cnt == CNT_FULL) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7)
                            r_state <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_clk_cnt == CNT_FULL) begin
                        r_clk_cnt   <= '0;
                        r_state     <= ST_IDLE;
                        r_led_rx    <= 1'b0;
                        r_byte_vld  <= r_rx_sync;
                        r_frame_err <= !r_rx_sync;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_led_rx <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_phase_lo <= 1'b0;
            r_hi       <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
            r_count    <= '0;
        end else if (!enable) begin
            r_phase_lo <= 1'b0;
            r_word_vld <= 1'b0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_count    <= '0;
        end else begin
            r_word_vld <= 1'b0;
            r_we       <= 1'b0;
            if (r_byte_vld && !r_done) begin
                if (!r_phase_lo) begin
                    r_hi       <= r_shift;
                    r_phase_lo <= 1'b1;
                end else begin
                    r_word     <= {r_hi, r_shift};
                    r_word_vld <= 1'b1;
                    r_phase_lo <= 1'b0;
                end
            end
            if (r_word_vld && !r_done) begin
                if (r_word == END_WORD) begin
                    r_done <= 1'b1;
                end else begin
                    r_data <= r_word;
                    r_we   <= 1'b1;
                end
            end
            // Address advances after the strobe so addr_io is valid during it.
            if (r_we) begin
                r_addr <= r_addr + 1'b1;
                if (r_count != 16'hFFFF)
                    r_count <= r_count + 1'b1;
            end
        end
    end

    assign mem.addr_io    = r_addr;
    assign mem.data_in_io = r_data;
    assign mem.we_io      = r_we;
    assign led_rx         = r_led_rx;
    assign done           = r_done;
    assign frame_err      = r_frame_err;
    assign word_count     = r_count;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: vector table, hand-written corner sequences and a randomized byte stream
// checked against a word-level reference model.
module tb_uart_mem_loader;
    localparam int CPB    = 16;
    localparam int ADDR_W = 4;

    logic        clk_100 = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic        rx      = 1'b1;
    logic        led_rx;
    logic        done;
    logic        frame_err;
    logic [15:0] word_count;

    uart_mem_loader_if #(.ADDR_W(ADDR_W)) mif ();

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   ('0),
        .END_WORD    (16'hFFFF)
    ) dut (
        .clk_100   (clk_100),
        .rst       (rst),
        .enable    (enable),
        .rx        (rx),
        .mem       (mif),
        .led_rx    (led_rx),
        .done      (done),
        .frame_err (frame_err),
        .word_count(word_count)
    );

    always #5 clk_100 = ~clk_100;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int start_cyc   = 0;
    int we_rise_cyc = 0;
    int ferr_cnt    = 0;
    logic prev_we   = 1'b0;
    logic prev_ferr = 1'b0;
    logic [ADDR_W-1:0] cap_addr[$];
    logic [15:0]       cap_data[$];

    always @(posedge clk_100) cyc <= cyc + 1;

    always @(negedge clk_100) begin
        if (mif.we_io) begin
            cap_addr.push_back(mif.addr_io);
            cap_data.push_back(mif.data_in_io);
            n_cmp++;
            if (prev_we) begin
                n_fail++;
                $display("FAIL we_pulse_width: strobe high 2+ cycles, required 1");
            end else begin
                we_rise_cyc = cyc;
            end
        end
        if (frame_err) begin
            ferr_cnt++;
            n_cmp++;
            if (prev_ferr) begin
                n_fail++;
                $display("FAIL ferr_pulse_width: frame_err high 2+ cycles, required 1");
            end
        end
        prev_we   = mif.we_io;
        prev_ferr = frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Caller is on a falling clock edge; rst_bit>=0 aborts the frame with a reset at that data bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int rst_bit);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk_100);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk_100);
                rst = 1'b0;
                rx  = 1'b1;
                return;
            end
            rx = b[i];
            repeat (CPB) @(negedge clk_100);
        end
        rx = stop;
        repeat (CPB) @(negedge clk_100);
        rx = 1'b1;
        repeat (CPB) @(negedge clk_100);
    endtask

    task automatic pulse_enable();
        enable = 1'b0;
        repeat (3) @(negedge clk_100);
        enable = 1'b1;
        repeat (3) @(negedge clk_100);
    endtask

    typedef struct {
        logic              bad;
        logic [7:0]        b0;
        logic [7:0]        b1;
        int                exp_nwr;
        logic [ADDR_W-1:0] exp_waddr;
        logic [15:0]       exp_data;
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0]       exp_count;
        logic              exp_done;
        int                exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic apply_row(input int i);
        int n0, f0;
        n0 = cap_data.size();
        f0 = ferr_cnt;
        if (vecs[i].bad) send_byte(8'h55, 1'b0, -1);
        send_byte(vecs[i].b0, 1'b1, -1);
        send_byte(vecs[i].b1, 1'b1, -1);
        chk($sformatf("row%0d_nwr", i), cap_data.size() - n0, vecs[i].exp_nwr);
        if (vecs[i].exp_nwr == 1 && cap_data.size() > n0) begin
            chk($sformatf("row%0d_waddr", i), cap_addr[n0], vecs[i].exp_waddr);
            chk($sformatf("row%0d_wdata", i), cap_data[n0], vecs[i].exp_data);
        end
        chk($sformatf("row%0d_addr", i), mif.addr_io, vecs[i].exp_addr);
        chk($sformatf("row%0d_count", i), word_count, vecs[i].exp_count);
        chk($sformatf("row%0d_done", i), done, vecs[i].exp_done);
        chk($sformatf("row%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
    endtask

    initial begin
        int n0, f0;
        logic              m_phase, m_done;
        logic [7:0]        m_hi, b;
        logic [15:0]       m_count, w;
        logic [ADDR_W-1:0] m_addr;
        logic [ADDR_W-1:0] e_addr[$];
        logic [15:0]       e_data[$];
        int                e_ferr;
        logic              ok;

        vecs[0] = '{1'b0, 8'hE8, 8'h12, 1, 4'd0, 16'hE812, 4'd1, 16'd1, 1'b0, 0};
        vecs[1] = '{1'b0, 8'hE4, 8'h51, 1, 4'd1, 16'hE451, 4'd2, 16'd2, 1'b0, 0};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 0, 4'd0, 16'h0000, 4'd2, 16'd2, 1'b1, 0};
        vecs[3] = '{1'b0, 8'h00, 8'h07, 1, 4'd0, 16'h0007, 4'd1, 16'd1, 1'b0, 0};
        vecs[4] = '{1'b1, 8'h12, 8'h34, 1, 4'd1, 16'h1234, 4'd2, 16'd2, 1'b0, 1};

        repeat (4) @(negedge clk_100);
        chk("rst_addr", mif.addr_io, 0);
        chk("rst_data", mif.data_in_io, 0);
        chk("rst_we", mif.we_io, 0);
        chk("rst_done", done, 0);
        chk("rst_count", word_count, 0);
        chk("rst_led", led_rx, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;
        @(negedge clk_100);
        enable = 1'b1;
        repeat (4) @(negedge clk_100);

        for (int i = 0; i < 3; i++) apply_row(i);

        // Bytes after done are received but change nothing.
        n0 = cap_data.size();
        send_byte(8'h01, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        chk("done_nowr", cap_data.size() - n0, 0);
        chk("done_sticky", done, 1);

        enable = 1'b0;
        repeat (3) @(negedge clk_100);
        chk("dis_done", done, 0);
        chk("dis_addr", mif.addr_io, 0);
        chk("dis_count", word_count, 0);
        chk("dis_data_hold", mif.data_in_io, 16'hE451);
        enable = 1'b1;
        repeat (3) @(negedge clk_100);

        for (int i = 3; i < 5; i++) apply_row(i);

        // Short low glitch on the line is rejected.
        n0 = cap_data.size();
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (6) @(negedge clk_100);
        chk("glitch_led_hi", led_rx, 1);
        rx = 1'b1;
        repeat (40) @(negedge clk_100);
        chk("glitch_led_lo", led_rx, 0);
        chk("glitch_nowr", cap_data.size() - n0, 0);
        chk("glitch_noferr", ferr_cnt - f0, 0);

        // Start-bit edge to strobe: 2 sync + 1 detect + half bit + 9 bits + 2 pipeline cycles.
        n0 = cap_data.size();
        send_byte(8'hAA, 1'b1, -1);
        send_byte(8'hBB, 1'b1, -1);
        chk("lat_nwr", cap_data.size() - n0, 1);
        chk("lat_cycles", we_rise_cyc - start_cyc, 3 + CPB / 2 + 9 * CPB + 2);
        if (cap_data.size() > n0) chk("lat_data", cap_data[n0], 16'hAABB);

        // Reset in the middle of the second byte abandons the pair.
        send_byte(8'h11, 1'b1, -1);
        send_byte(8'h22, 1'b1, 4);
        repeat (2 * CPB) @(negedge clk_100);
        chk("midrst_addr", mif.addr_io, 0);
        chk("midrst_count", word_count, 0);
        n0 = cap_data.size();
        send_byte(8'hAB, 1'b1, -1);
        send_byte(8'hCD, 1'b1, -1);
        chk("midrst_nwr", cap_data.size() - n0, 1);
        if (cap_data.size() > n0) begin
            chk("midrst_waddr", cap_addr[n0], 0);
            chk("midrst_wdata", cap_data[n0], 16'hABCD);
        end
        chk("midrst_cnt1", word_count, 1);

        // Random stream against a word-level model; enough words to wrap the address.
        pulse_enable();
        cap_addr.delete();
        cap_data.delete();
        f0 = ferr_cnt;
        m_phase = 0; m_done = 0; m_hi = 0; m_count = 0; m_addr = 0; e_ferr = 0;
        for (int n = 0; n < 48; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_byte(b, ok, -1);
            if (!ok) begin
                e_ferr++;
            end else if (!m_done) begin
                if (!m_phase) begin
                    m_hi = b;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                    w = {m_hi, b};
                    if (w == 16'hFFFF) begin
                        m_done = 1;
                    end else begin
                        e_addr.push_back(m_addr);
                        e_data.push_back(w);
                        m_addr = m_addr + 1'b1;
                        if (m_count != 16'hFFFF) m_count = m_count + 1'b1;
                    end
                end
            end
        end
        chk("rnd_nwr", cap_data.size(), e_data.size());
        for (int k = 0; k < e_data.size() && k < cap_data.size(); k++) begin
            chk($sformatf("rnd_waddr%0d", k), cap_addr[k], e_addr[k]);
            chk($sformatf("rnd_wdata%0d", k), cap_data[k], e_data[k]);
        end
        chk("rnd_addr", mif.addr_io, m_addr);
        chk("rnd_count", word_count, m_count);
        chk("rnd_done", done, m_done);
        chk("rnd_ferr", ferr_cnt - f0, e_ferr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
